multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the single-issue MIPS datapath.
- Captures the fetched instruction's opcode and funct fields and sequences the instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath control input: PC enable, write-register mux, regfile write enable, ALU operand mux, ALU function, data-memory strobes and size, and the writeback mux.
- Reports branch/jump resolution and halts on illegal opcodes.

Parameters:
- HALT_ON_ILLEGAL, 1, when 1 an unknown opcode/funct enters HALT; when 0 it is retired as a NOP.
- MEM_WAIT, 1, cycles spent in MEM for loads before WB (1..3).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode_in  input  6  instruction[31:26] from the datapath.
- func_in  input  6  instruction[5:0] from the datapath.
- alu_branch_in  input  1  ALU branch-condition result.
- alu_jump_in  input  1  ALU jump indication.
- pc_en_out  output  1  PC register enable.
- inst_mux_sel_out  output  1  write-register select: 0=rt, 1=rd.
- regfile_we_out  output  1  register file write enable.
- alu_mux_sel_out  output  1  ALU operand B: 0=rt data, 1=sign-extended immediate.
- alu_func_out  output  6  ALU function code.
- data_mem_re_out  output  1  data memory read enable.
- data_mem_we_out  output  1  data memory write enable.
- data_mem_size_out  output  2  access size: 00=byte, 01=half, 11=word.
- data_mem_mux_sel_out  output  1  writeback source: 0=ALU, 1=memory.
- branch_taken_out  output  1  one-cycle pulse when a branch resolves taken.
- jump_out  output  1  one-cycle pulse for j/jal/jr.
- halt_out  output  1  high while in HALT.
- state_out  output  3  current state encoding, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Reset:
  - state=FETCH, instruction latch cleared (opcode=0, funct=0), MEM counter=0.
  - All outputs 0; state_out=0.
  - Reset asserted in any state, including mid-MEM, returns to FETCH on the next edge with no write strobe in that cycle.
- FETCH (1 cycle): all strobes 0; next DECODE.
- DECODE:
  - Latch opcode_in and func_in into internal registers; all later states use the latched copy only.
  - Illegal opcode/funct goes to HALT (HALT_ON_ILLEGAL=1) or WB with regfile_we=0 (HALT_ON_ILLEGAL=0); otherwise next EXEC.
- EXEC:
  - alu_func_out and alu_mux_sel_out are valid.
  - R-type (opcode 0): alu_func_out = latched funct; funct 0x08 (jr) is a jump.
  - I-type mapping:
    - addi/addiu and lw/lb/lbu/lh/lhu/sw/sb/sh → 0x21.
    - andi → 0x24, ori → 0x25, xori → 0x26, slti → 0x2A, sltiu → 0x2B.
    - beq → 0x30, bne → 0x31, j/jal → 0x32.
  - alu_mux_sel_out=1 for all I-type except beq/bne.
  - Branch: branch_taken_out = alu_branch_in for one cycle; pc_en_out=1; next FETCH (3 cycles).
  - j/jal/jr: jump_out=1, pc_en_out=1; next FETCH.
  - Loads/stores: next MEM. All others: next WB.
- MEM:
  - Load:
    - data_mem_re_out=1 for MEM_WAIT cycles, via a counter that counts 0..MEM_WAIT-1.
    - Size from opcode: lb/lbu=00, lh/lhu=01, lw=11.
    - Next WB.
  - Store:
    - data_mem_we_out=1 for exactly 1 cycle; sb=00, sh=01, sw=11.
    - pc_en_out=1 in that cycle; next FETCH.
    - Store CPI = 4 regardless of MEM_WAIT.
- WB (1 cycle):
  - regfile_we_out=1 and pc_en_out=1.
  - inst_mux_sel_out=1 for R-type, else 0.
  - data_mem_mux_sel_out=1 for loads, else 0.
  - alu_func_out and size are held from the previous state.
  - Next FETCH.
  - Writeback to register 0 is not suppressed here; the regfile ignores it.
- HALT: absorbing; all strobes 0, halt_out=1; exit only via reset.
- Invariants:
  - pc_en_out is high for exactly one cycle per retired instruction.
  - regfile_we_out and data_mem_we_out are never high together.
  - data_mem_re_out and data_mem_we_out are never high together.
- CPI with MEM_WAIT=1: R/I-ALU 4, load 5, store 4, branch/jump 3.
- Outputs are a registered-state Moore decode plus the latched instruction; no combinational path from opcode_in/func_in to any output.

Test Plan:
- reset held 3 cycles, then released with opcode_in=0, func_in=0x21 → state_out 0→1→2→4→0; pc_en_out and regfile_we_out high only in WB (cycle 4); inst_mux_sel_out=1, alu_func_out=0x21.
- lw (opcode 0x23), MEM_WAIT=2 → data_mem_re_out high 2 cycles; data_mem_size_out=11; WB has data_mem_mux_sel_out=1, regfile_we_out=1; 6 cycles total.
- sb (0x28) → data_mem_we_out high exactly 1 cycle, size=00, pc_en_out in the same cycle, regfile_we_out never high; 4 cycles.
- beq (0x04) with alu_branch_in=1, then with alu_branch_in=0 → alu_func_out=0x30, alu_mux_sel_out=0; branch_taken_out pulses 1 then stays 0; pc_en_out pulses in EXEC both times.
- Opcode 0x3F with HALT_ON_ILLEGAL=1 → halt_out=1 from cycle 3 onward, no strobes for 20 cycles; reset pulse → state_out=0. Same opcode with HALT_ON_ILLEGAL=0 → retired as NOP, regfile_we_out stays 0.
- Change opcode_in after DECODE, and assert reset during a load's MEM state → decode uses the latched value; reset returns state_out=0 next edge with data_mem_re_out/we_out=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the single-issue MIPS datapath: latches opcode/funct in DECODE
// and sequences FETCH/DECODE/EXEC/MEM/WB, driving every datapath control input as a Moore decode.
module multicycle_control #(
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int MEM_WAIT        = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode_in,
  input  logic [5:0] func_in,
  input  logic       alu_branch_in,
  input  logic       alu_jump_in,
  output logic       pc_en_out,
  output logic       inst_mux_sel_out,
  output logic       regfile_we_out,
  output logic       alu_mux_sel_out,
  output logic [5:0] alu_func_out,
  output logic       data_mem_re_out,
  output logic       data_mem_we_out,
  output logic [1:0] data_mem_size_out,
  output logic       data_mem_mux_sel_out,
  output logic       branch_taken_out,
  output logic       jump_out,
  output logic       halt_out,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] MEM_LAST = 2'(MEM_WAIT - 1);

  function automatic logic f_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, FN_JR,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: ok = 1'b1;
          default:      ok = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: ok = 1'b1;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [5:0] f_alu_code(input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] code;
    code = 6'h00;
    case (op)
      OP_RTYPE: code = fn;
      OP_ADDI, OP_ADDIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: code = 6'h21;
      OP_ANDI:  code = 6'h24;
      OP_ORI:   code = 6'h25;
      OP_XORI:  code = 6'h26;
      OP_SLTI:  code = 6'h2A;
      OP_SLTIU: code = 6'h2B;
      OP_BEQ:   code = 6'h30;
      OP_BNE:   code = 6'h31;
      OP_J, OP_JAL: code = 6'h32;
      default:  code = 6'h00;
    endcase
    return code;
  endfunction

  function automatic logic f_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic f_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic f_is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic f_is_jump(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_J) || (op == OP_JAL) || ((op == OP_RTYPE) && (fn == FN_JR));
  endfunction

  function automatic logic [1:0] f_mem_size(input logic [5:0] op);
    logic [1:0] sz;
    case (op)
      OP_LH, OP_LHU, OP_SH: sz = 2'b01;
      OP_LW, OP_SW:         sz = 2'b11;
      default:              sz = 2'b00;
    endcase
    return sz;
  endfunction

  state_t     state, state_nxt;
  logic [5:0] op_q, fn_q;
  logic       ill_q;
  logic [1:0] mem_cnt;

  // Jump resolution comes from the latched opcode; the ALU's indication is informational only.
  logic unused_alu_jump;
  assign unused_alu_jump = alu_jump_in;

  logic       is_ld, is_st, is_br, is_jmp, is_r;
  logic [5:0] code_q;
  logic [1:0] size_q;

  always_comb begin
    is_ld  = f_is_load(op_q);
    is_st  = f_is_store(op_q);
    is_br  = f_is_branch(op_q);
    is_jmp = f_is_jump(op_q, fn_q);
    is_r   = (op_q == OP_RTYPE) && !ill_q;
    code_q = ill_q ? 6'h00 : f_alu_code(op_q, fn_q);
    size_q = f_mem_size(op_q);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Instruction latch and load wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q    <= 6'h00;
      fn_q    <= 6'h00;
      ill_q   <= 1'b0;
      mem_cnt <= 2'd0;
    end else begin
      if (state == DECODE) begin
        op_q  <= opcode_in;
        fn_q  <= func_in;
        ill_q <= !f_legal(opcode_in, func_in);
      end
      if ((state == MEM) && is_ld && (mem_cnt != MEM_LAST)) mem_cnt <= mem_cnt + 2'd1;
      else                                                   mem_cnt <= 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        if (f_legal(opcode_in, func_in)) state_nxt = EXEC;
        else if (HALT_ON_ILLEGAL != 0)   state_nxt = HALT;
        else                             state_nxt = WB;
      end
      EXEC: begin
        if (is_br || is_jmp)     state_nxt = FETCH;
        else if (is_ld || is_st) state_nxt = MEM;
        else                     state_nxt = WB;
      end
      MEM: begin
        if (is_st)                    state_nxt = FETCH;
        else if (mem_cnt == MEM_LAST) state_nxt = WB;
      end
      WB:      state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    pc_en_out            = 1'b0;
    inst_mux_sel_out     = 1'b0;
    regfile_we_out       = 1'b0;
    alu_mux_sel_out      = 1'b0;
    alu_func_out         = 6'h00;
    data_mem_re_out      = 1'b0;
    data_mem_we_out      = 1'b0;
    data_mem_size_out    = 2'b00;
    data_mem_mux_sel_out = 1'b0;
    branch_taken_out     = 1'b0;
    jump_out             = 1'b0;
    halt_out             = 1'b0;
    state_out            = state;
    case (state)
      EXEC: begin
        alu_func_out    = code_q;
        alu_mux_sel_out = !is_r && !is_br && !ill_q;
        if (is_br) begin
          pc_en_out        = 1'b1;
          branch_taken_out = alu_branch_in;
        end
        if (is_jmp) begin
          pc_en_out = 1'b1;
          jump_out  = 1'b1;
        end
      end
      MEM: begin
        alu_func_out      = code_q;
        alu_mux_sel_out   = 1'b1;
        data_mem_size_out = size_q;
        data_mem_re_out   = is_ld;
        if (is_st) begin
          data_mem_we_out = 1'b1;
          pc_en_out       = 1'b1;
        end
      end
      WB: begin
        alu_func_out         = code_q;
        alu_mux_sel_out      = !is_r && !ill_q;
        data_mem_size_out    = size_q;
        pc_en_out            = 1'b1;
        regfile_we_out       = !ill_q;
        inst_mux_sel_out     = is_r;
        data_mem_mux_sel_out = is_ld && !ill_q;
      end
      HALT:    halt_out = 1'b1;
      default: ;
    endcase
    // A reset arriving mid-instruction must not let a strobe escape in its own cycle.
    if (reset) begin
      pc_en_out        = 1'b0;
      regfile_we_out   = 1'b0;
      data_mem_re_out  = 1'b0;
      data_mem_we_out  = 1'b0;
      branch_taken_out = 1'b0;
      jump_out         = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors against hand-computed tables,
// using one instance with HALT_ON_ILLEGAL=1/MEM_WAIT=2 and one with HALT_ON_ILLEGAL=0/MEM_WAIT=1.
module tb_multicycle_control;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, reset2;
  logic [5:0] opcode, func;
  logic       alu_branch, alu_jump;

  logic       pc_en, inst_mux, rwe, alu_mux, re, we, dmux, br, jmp, halt;
  logic [5:0] alu_func;
  logic [1:0] size;
  logic [2:0] state;

  logic       n_pc_en, n_inst_mux, n_rwe, n_alu_mux, n_re, n_we, n_dmux, n_br, n_jmp, n_halt;
  logic [5:0] n_alu_func;
  logic [1:0] n_size;
  logic [2:0] n_state;

  multicycle_control #(.HALT_ON_ILLEGAL(1), .MEM_WAIT(2)) dut (
    .clock(clock), .reset(reset), .opcode_in(opcode), .func_in(func),
    .alu_branch_in(alu_branch), .alu_jump_in(alu_jump),
    .pc_en_out(pc_en), .inst_mux_sel_out(inst_mux), .regfile_we_out(rwe),
    .alu_mux_sel_out(alu_mux), .alu_func_out(alu_func), .data_mem_re_out(re),
    .data_mem_we_out(we), .data_mem_size_out(size), .data_mem_mux_sel_out(dmux),
    .branch_taken_out(br), .jump_out(jmp), .halt_out(halt), .state_out(state)
  );

  multicycle_control #(.HALT_ON_ILLEGAL(0), .MEM_WAIT(1)) dut_nop (
    .clock(clock), .reset(reset2), .opcode_in(opcode), .func_in(func),
    .alu_branch_in(alu_branch), .alu_jump_in(alu_jump),
    .pc_en_out(n_pc_en), .inst_mux_sel_out(n_inst_mux), .regfile_we_out(n_rwe),
    .alu_mux_sel_out(n_alu_mux), .alu_func_out(n_alu_func), .data_mem_re_out(n_re),
    .data_mem_we_out(n_we), .data_mem_size_out(n_size), .data_mem_mux_sel_out(n_dmux),
    .branch_taken_out(n_br), .jump_out(n_jmp), .halt_out(n_halt), .state_out(n_state)
  );

  // ctl = {state, pc_en, regfile_we, re, we, halt, branch_taken, jump}
  // aux = {alu_func, alu_mux, size, inst_mux, dmux}
  wire [9:0]  ctl   = {state, pc_en, rwe, re, we, halt, br, jmp};
  wire [10:0] aux   = {alu_func, alu_mux, size, inst_mux, dmux};
  wire [9:0]  n_ctl = {n_state, n_pc_en, n_rwe, n_re, n_we, n_halt, n_br, n_jmp};
  wire [10:0] n_aux = {n_alu_func, n_alu_mux, n_size, n_inst_mux, n_dmux};

  localparam logic [10:0] M_FN  = 11'h7E0;
  localparam logic [10:0] M_MUX = 11'h010;
  localparam logic [10:0] M_SZ  = 11'h00C;
  localparam logic [10:0] M_IM  = 11'h002;
  localparam logic [10:0] M_DM  = 11'h001;

  int compared   = 0;
  int mismatched = 0;

  function automatic logic [10:0] ax(input logic [5:0] fn, input logic mux,
                                     input logic [1:0] sz, input logic im, input logic dm);
    return {fn, mux, sz, im, dm};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset2 = 1'b1;
    opcode = 6'h00; func = 6'h00; alu_branch = 1'b0; alu_jump = 1'b0;
    repeat (3) tick();
    compared++;
    if (ctl !== 10'b000_0000000) begin
      mismatched++; $display("FAIL reset_ctl: got %b want %b", ctl, 10'b0);
    end
    compared++;
    if (aux !== 11'h000) begin
      mismatched++; $display("FAIL reset_aux: got %h want 000", aux);
    end
  endtask

  task automatic test_rtype();
    logic [9:0]  ec [5];
    logic [10:0] ea [5], em [5];
    ec = '{10'b000_0000000, 10'b001_0000000, 10'b010_0000000, 10'b100_1100000, 10'b000_0000000};
    ea = '{11'h0, 11'h0, ax(6'h21, 1'b0, 2'b00, 1'b0, 1'b0), ax(6'h21, 1'b0, 2'b00, 1'b1, 1'b0), 11'h0};
    em = '{11'h0, 11'h0, M_FN | M_MUX, M_FN | M_IM | M_DM, 11'h0};
    opcode = 6'h00; func = 6'h21;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      compared++;
      if (ctl !== ec[i]) begin
        mismatched++; $display("FAIL addu_ctl cyc%0d: got %b want %b", i, ctl, ec[i]);
      end
      if (em[i] != 11'h0) begin
        compared++;
        if ((aux & em[i]) !== (ea[i] & em[i])) begin
          mismatched++; $display("FAIL addu_aux cyc%0d: got %h want %h", i, aux & em[i], ea[i] & em[i]);
        end
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0] ops [6]   = '{6'h0D, 6'h0A, 6'h0E, 6'h0C, 6'h0B, 6'h08};
    logic [5:0] codes [6] = '{6'h25, 6'h2A, 6'h26, 6'h24, 6'h2B, 6'h21};
    logic [9:0]  ec [5];
    logic [10:0] ea [5], em [5];
    for (int k = 0; k < 6; k++) begin
      ec = '{10'b000_0000000, 10'b001_0000000, 10'b010_0000000, 10'b100_1100000, 10'b000_0000000};
      ea = '{11'h0, 11'h0, ax(codes[k], 1'b1, 2'b00, 1'b0, 1'b0), ax(codes[k], 1'b0, 2'b00, 1'b0, 1'b0), 11'h0};
      em = '{11'h0, 11'h0, M_FN | M_MUX, M_FN | M_IM | M_DM, 11'h0};
      opcode = ops[k]; func = 6'h3F;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) tick();
        compared++;
        if (ctl !== ec[i]) begin
          mismatched++; $display("FAIL itype%0h_ctl cyc%0d: got %b want %b", ops[k], i, ctl, ec[i]);
        end
        if (em[i] != 11'h0) begin
          compared++;
          if ((aux & em[i]) !== (ea[i] & em[i])) begin
            mismatched++; $display("FAIL itype%0h_aux cyc%0d: got %h want %h", ops[k], i, aux & em[i], ea[i] & em[i]);
          end
        end
      end
    end
  endtask

  task automatic test_load();
    logic [9:0]  ec [7];
    logic [10:0] ea [7], em [7];
    ec = '{10'b000_0000000, 10'b001_0000000, 10'b010_0000000, 10'b011_0010000,
           10'b011_0010000, 10'b100_1100000, 10'b000_0000000};
    ea = '{11'h0, 11'h0, ax(6'h21, 1'b1, 2'b00, 1'b0, 1'b0), ax(6'h00, 1'b0, 2'b11, 1'b0, 1'b0),
           ax(6'h00, 1'b0, 2'b11, 1'b0, 1'b0), ax(6'h21, 1'b0, 2'b11, 1'b0, 1'b1), 11'h0};
    em = '{11'h0, 11'h0, M_FN | M_MUX, M_SZ, M_SZ, M_FN | M_SZ | M_IM | M_DM, 11'h0};
    opcode = 6'h23; func = 6'h00;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      compared++;
      if (ctl !== ec[i]) begin
        mismatched++; $display("FAIL lw_ctl cyc%0d: got %b want %b", i, ctl, ec[i]);
      end
      if (em[i] != 11'h0) begin
        compared++;
        if ((aux & em[i]) !== (ea[i] & em[i])) begin
          mismatched++; $display("FAIL lw_aux cyc%0d: got %h want %h", i, aux & em[i], ea[i] & em[i]);
        end
      end
    end
  endtask

  task automatic test_store();
    logic [5:0] ops [3]   = '{6'h28, 6'h29, 6'h2B};
    logic [1:0] sizes [3] = '{2'b00, 2'b01, 2'b11};
    logic [9:0]  ec [5];
    logic [10:0] ea [5], em [5];
    for (int k = 0; k < 3; k++) begin
      ec = '{10'b000_0000000, 10'b001_0000000, 10'b010_0000000, 10'b011_1001000, 10'b000_0000000};
      ea = '{11'h0, 11'h0, ax(6'h21, 1'b1, 2'b00, 1'b0, 1'b0), ax(6'h00, 1'b0, sizes[k], 1'b0, 1'b0), 11'h0};
      em = '{11'h0, 11'h0, M_FN | M_MUX, M_SZ, 11'h0};
      opcode = ops[k]; func = 6'h00;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) tick();
        compared++;
        if (ctl !== ec[i]) begin
          mismatched++; $display("FAIL store%0h_ctl cyc%0d: got %b want %b", ops[k], i, ctl, ec[i]);
        end
        if (em[i] != 11'h0) begin
          compared++;
          if ((aux & em[i]) !== (ea[i] & em[i])) begin
            mismatched++; $display("FAIL store%0h_aux cyc%0d: got %h want %h", ops[k], i, aux & em[i], ea[i] & em[i]);
          end
        end
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0] ops [6]   = '{6'h04, 6'h04, 6'h05, 6'h00, 6'h02, 6'h03};
    logic [5:0] fns [6]   = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00};
    logic       cond [6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [5:0] codes [6] = '{6'h30, 6'h30, 6'h31, 6'h08, 6'h32, 6'h32};
    logic [9:0]  ec [4];
    logic [10:0] ea [4], em [4];
    for (int k = 0; k < 6; k++) begin
      ec = '{10'b000_0000000, 10'b001_0000000, 10'b010_1000000, 10'b000_0000000};
      if (k < 3) ec[2][1] = cond[k];
      else       ec[2][0] = 1'b1;
      ea = '{11'h0, 11'h0, ax(codes[k], 1'b0, 2'b00, 1'b0, 1'b0), 11'h0};
      em = '{11'h0, 11'h0, (k < 4) ? (M_FN | M_MUX) : M_FN, 11'h0};
      opcode = ops[k]; func = fns[k]; alu_branch = cond[k];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        compared++;
        if (ctl !== ec[i]) begin
          mismatched++; $display("FAIL brj%0d_ctl cyc%0d: got %b want %b", k, i, ctl, ec[i]);
        end
        if (em[i] != 11'h0) begin
          compared++;
          if ((aux & em[i]) !== (ea[i] & em[i])) begin
            mismatched++; $display("FAIL brj%0d_aux cyc%0d: got %h want %h", k, i, aux & em[i], ea[i] & em[i]);
          end
        end
      end
    end
    alu_branch = 1'b0;
  endtask

  task automatic test_latch_and_reset_mid_mem();
    logic [9:0]  ec [5];
    logic [10:0] ea [5], em [5];
    ec = '{10'b000_0000000, 10'b001_0000000, 10'b010_0000000, 10'b100_1100000, 10'b000_0000000};
    ea = '{11'h0, 11'h0, ax(6'h20, 1'b0, 2'b00, 1'b0, 1'b0), ax(6'h20, 1'b0, 2'b00, 1'b1, 1'b0), 11'h0};
    em = '{11'h0, 11'h0, M_FN | M_MUX, M_FN | M_IM | M_DM, 11'h0};
    opcode = 6'h00; func = 6'h20;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      compared++;
      if (ctl !== ec[i]) begin
        mismatched++; $display("FAIL latch_ctl cyc%0d: got %b want %b", i, ctl, ec[i]);
      end
      if (em[i] != 11'h0) begin
        compared++;
        if ((aux & em[i]) !== (ea[i] & em[i])) begin
          mismatched++; $display("FAIL latch_aux cyc%0d: got %h want %h", i, aux & em[i], ea[i] & em[i]);
        end
      end
      if (i == 2) begin
        opcode = 6'h23; func = 6'h08;
      end
    end
    opcode = 6'h23; func = 6'h00;
    repeat (3) tick();
    compared++;
    if (ctl !== 10'b011_0010000) begin
      mismatched++; $display("FAIL midmem_pre: got %b want %b", ctl, 10'b011_0010000);
    end
    reset = 1'b1;
    #1;
    compared++;
    if ({rwe, we} !== 2'b00) begin
      mismatched++; $display("FAIL midmem_wstrobe: got %b want 00", {rwe, we});
    end
    tick();
    compared++;
    if (ctl !== 10'b000_0000000) begin
      mismatched++; $display("FAIL midmem_reset: got %b want %b", ctl, 10'b0);
    end
    reset = 1'b0;
  endtask

  task automatic test_halt();
    opcode = 6'h3F; func = 6'h00;
    for (int i = 0; i < 22; i++) begin
      if (i > 0) tick();
      compared++;
      if (ctl !== ((i == 0) ? 10'b000_0000000 : (i == 1) ? 10'b001_0000000 : 10'b111_0000100)) begin
        mismatched++; $display("FAIL halt_ctl cyc%0d: got %b", i, ctl);
      end
    end
    reset = 1'b1;
    tick();
    compared++;
    if (ctl !== 10'b000_0000000) begin
      mismatched++; $display("FAIL halt_reset: got %b want %b", ctl, 10'b0);
    end
    reset = 1'b0;
    opcode = 6'h00;
  endtask

  task automatic test_nop_and_load_cpi();
    logic [9:0]  ec [9];
    logic [10:0] ea [9], em [9];
    reset = 1'b1;
    tick();
    reset2 = 1'b0;
    ec = '{10'b000_0000000, 10'b001_0000000, 10'b100_1000000, 10'b000_0000000,
           10'b001_0000000, 10'b010_0000000, 10'b011_0010000, 10'b100_1100000, 10'b000_0000000};
    ea = '{11'h0, 11'h0, ax(6'h00, 1'b0, 2'b00, 1'b0, 1'b0), 11'h0, 11'h0, 11'h0,
           ax(6'h00, 1'b0, 2'b11, 1'b0, 1'b0), ax(6'h21, 1'b0, 2'b11, 1'b0, 1'b1), 11'h0};
    em = '{11'h0, 11'h0, M_DM, 11'h0, 11'h0, 11'h0, M_SZ, M_FN | M_SZ | M_DM, 11'h0};
    opcode = 6'h3F; func = 6'h00;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      compared++;
      if (n_ctl !== ec[i]) begin
        mismatched++; $display("FAIL nop_lw_ctl cyc%0d: got %b want %b", i, n_ctl, ec[i]);
      end
      if (em[i] != 11'h0) begin
        compared++;
        if ((n_aux & em[i]) !== (ea[i] & em[i])) begin
          mismatched++; $display("FAIL nop_lw_aux cyc%0d: got %h want %h", i, n_aux & em[i], ea[i] & em[i]);
        end
      end
      if (i == 3) opcode = 6'h23;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load();
    test_store();
    test_branch_jump();
    test_latch_and_reset_mid_mem();
    test_halt();
    test_nop_and_load_cpi();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
